// File: rtl/count_seq_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_checker_pkg
// Description : Shared types and constants for the count sequence checker.
//               Holds the checker state encoding, default widths, and the
//               helper that gives the maximum count for a given width.
// Revision    : 1.0 - initial release
// ============================================================================
package count_seq_checker_pkg;

  // Checker state encoding (2 bits).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ERR_CNT_W = 8;

  // Largest value of a default-width counter; the expected value wraps here.
  localparam int CNT_MAX = (1 << DEF_WIDTH) - 1;

  // Largest value of a counter of arbitrary width w.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_seq_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with a clear input. A clear that lands
//               in the same cycle as an increment leaves the counter at 1, so
//               the event that coincided with the clear is not lost.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high
//               inc   - count one event
//               clr   - return to zero (to one if inc is also high)
//               q     - current count, holds at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != Q_MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_checker
// Description : On-chip observer for the enable/count interface of an
//               up-counter. It predicts the next count from the observed
//               enable and flags every cycle where the counter disagrees.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               mon_en         - arm the checker (low = idle)
//               clear          - clear sticky flag, tally and capture
//               enable, count  - observed counter interface
//               active         - checker is tracking
//               error          - one-cycle pulse per mismatch
//               error_sticky   - any mismatch since clear/reset
//               err_count      - saturating mismatch tally
//               first_err_exp  - expected value at first mismatch
//               first_err_got  - observed value at first mismatch
//               wrap           - one-cycle pulse on expected max->0
//               exp_value      - current expected value
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W,
  parameter int RESYNC    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mon_en,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     count,
  output logic                 active,
  output logic                 error,
  output logic                 error_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_got,
  output logic                 wrap,
  output logic [WIDTH-1:0]     exp_value
);

  localparam logic [WIDTH-1:0] EXP_MAX = WIDTH'(cnt_max(WIDTH));

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_d;
  logic             mismatch;
  logic             wrap_d;
  logic             capture_load;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mon_en) next_state = SYNC;
      SYNC:    next_state = mon_en ? TRACK : IDLE;
      TRACK:   if (!mon_en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Compare, expected-value prediction and event decode.
  always_comb begin
    mismatch = (state == TRACK) && (count != exp_q);
    exp_d    = exp_q;
    case (state)
      // The counter will have advanced by 'enable' at this same edge.
      SYNC: exp_d = count + WIDTH'(enable);
      TRACK: begin
        if (mon_en) begin
          if (mismatch && (RESYNC != 0)) begin
            exp_d = count + WIDTH'(enable);
          end else begin
            exp_d = exp_q + WIDTH'(enable);
          end
        end
      end
      default: exp_d = exp_q;
    endcase
    wrap_d       = (state == TRACK) && enable && (exp_q == EXP_MAX) && !mismatch;
    // A clear in the same cycle empties the capture, so this mismatch
    // becomes the new first error.
    capture_load = mismatch && (!error_sticky || clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q         <= '0;
      active        <= 1'b0;
      error         <= 1'b0;
      wrap          <= 1'b0;
      error_sticky  <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      exp_q  <= exp_d;
      active <= (next_state == TRACK);
      error  <= mismatch;
      wrap   <= wrap_d;

      if (mismatch) begin
        error_sticky <= 1'b1;
      end else if (clear) begin
        error_sticky <= 1'b0;
      end

      if (capture_load) begin
        first_err_exp <= exp_q;
        first_err_got <= count;
      end else if (clear) begin
        first_err_exp <= '0;
        first_err_got <= '0;
      end
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (mismatch),
    .clr  (clear),
    .q    (err_count)
  );

  assign exp_value = exp_q;

endmodule
`default_nettype wire
